// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and constants for the data memory arbiter.
// State encoding, requester IDs and default bus widths.
package dmem_arb_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Requester A/B and memory bus bundle for data_mem_arbiter.
// master: requesters + memory side; slave: the arbiter.
interface data_mem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_done;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_done;
  logic [DATA_W-1:0] b_rdata;

  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output mem_rdata,
    input  a_gnt, a_done, a_rdata,
    input  b_gnt, b_done, b_rdata,
    input  mem_en, mem_addr, mem_wdata, busy
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  mem_rdata,
    output a_gnt, a_done, a_rdata,
    output b_gnt, b_done, b_rdata,
    output mem_en, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Two-way round-robin pick with fixed-priority bypass.
// Ports: req_a/req_b, ptr in; win (ID), ptr_nxt out.
module rr_arb2
  import dmem_arb_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic req_a,
  input  logic req_b,
  input  logic ptr,
  output logic win,
  output logic ptr_nxt
);

  always_comb begin
    win     = REQ_A;
    ptr_nxt = ptr;
    unique case (1'b1)
      (req_a && req_b): begin
        if (RR_EN) begin
          // holder wins, pointer hands over
          win     = ptr;
          ptr_nxt = ~ptr;
        end else begin
          win = REQ_A;
        end
      end
      (req_a && !req_b): win = REQ_A;
      (!req_a && req_b): win = REQ_B;
      default:           win = REQ_A;
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter/sequencer for the 32x8 data memory.
// Ports: clock, reset (async, active-low), bus (slave modport).
module data_mem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter bit RR_EN  = 1'b1
) (
  input logic              clock,
  input logic              reset,
  data_mem_arbiter_if.slave bus
);

  state_t state;
  state_t state_nxt;

  logic              id;
  logic              we_q;
  logic              ptr;
  logic              win;
  logic              ptr_nxt;
  logic              any_req;
  logic              in_acc;
  logic              in_done;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] a_rd_q;
  logic [DATA_W-1:0] b_rd_q;

  assign any_req = bus.a_req || bus.b_req;

  rr_arb2 #(
    .RR_EN(RR_EN)
  ) u_arb (
    .req_a  (bus.a_req),
    .req_b  (bus.b_req),
    .ptr    (ptr),
    .win    (win),
    .ptr_nxt(ptr_nxt)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      id      <= REQ_A;
      we_q    <= 1'b0;
      ptr     <= REQ_A;
      addr_q  <= '0;
      wdata_q <= '0;
      a_rd_q  <= '0;
      b_rd_q  <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        id      <= win;
        ptr     <= ptr_nxt;
        we_q    <= (win == REQ_B) ? bus.b_we : bus.a_we;
        addr_q  <= (win == REQ_B) ? bus.b_addr : bus.a_addr;
        wdata_q <= (win == REQ_B) ? bus.b_wdata : bus.a_wdata;
      end
      // read-before-write: old contents captured at the write edge
      if (state == ACCESS) begin
        if (id == REQ_B) b_rd_q <= bus.mem_rdata;
        else             a_rd_q <= bus.mem_rdata;
      end
    end
  end

  assign in_acc  = (state == ACCESS);
  assign in_done = (state == DONE);

  assign bus.a_gnt     = in_acc && (id == REQ_A);
  assign bus.b_gnt     = in_acc && (id == REQ_B);
  assign bus.a_done    = in_done && (id == REQ_A);
  assign bus.b_done    = in_done && (id == REQ_B);
  assign bus.a_rdata   = a_rd_q;
  assign bus.b_rdata   = b_rd_q;
  assign bus.mem_en    = in_acc && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = in_acc || in_done;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter.
// Two DUTs: round-robin (dut0) and fixed priority (dut1).
module tb_data_mem_arbiter;

  typedef struct {
    bit         p;
    logic [7:0] d;
  } sb_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   en_cnt;

  logic [7:0] mem0 [32];
  logic [7:0] mem1 [32];
  logic [7:0] model [32];
  logic [7:0] last_rd [2];
  sb_t        sb_q [$];

  data_mem_arbiter_if #(.ADDR_W(5), .DATA_W(8)) bus0 ();
  data_mem_arbiter_if #(.ADDR_W(5), .DATA_W(8)) bus1 ();

  data_mem_arbiter #(
    .ADDR_W(5), .DATA_W(8), .RR_EN(1'b1)
  ) dut0 (
    .clock(clk),
    .reset(rst_n),
    .bus  (bus0)
  );

  data_mem_arbiter #(
    .ADDR_W(5), .DATA_W(8), .RR_EN(1'b0)
  ) dut1 (
    .clock(clk),
    .reset(rst_n),
    .bus  (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus0.mem_rdata = mem0[bus0.mem_addr];
  assign bus1.mem_rdata = mem1[bus1.mem_addr];

  always @(posedge clk) begin
    if (bus0.mem_en) mem0[bus0.mem_addr] <= bus0.mem_wdata;
    if (bus1.mem_en) mem1[bus1.mem_addr] <= bus1.mem_wdata;
  end

  always @(negedge clk) begin
    if (bus0.mem_en) en_cnt++;
  end

  task automatic clear_inputs;
    bus0.a_req = 0; bus0.a_we = 0; bus0.a_addr = 0; bus0.a_wdata = 0;
    bus0.b_req = 0; bus0.b_we = 0; bus0.b_addr = 0; bus0.b_wdata = 0;
    bus1.a_req = 0; bus1.a_we = 0; bus1.a_addr = 0; bus1.a_wdata = 0;
    bus1.b_req = 0; bus1.b_we = 0; bus1.b_addr = 0; bus1.b_wdata = 0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
  endtask

  // one complete transaction on dut0, checked cycle by cycle
  task automatic do_op(input bit p, input bit we,
                       input logic [4:0] addr, input logic [7:0] wd);
    sb_t        s;
    int         en0;
    logic       g_p, g_o, d_p, d_o;
    logic [7:0] rd_p, rd_o;
    en0 = en_cnt;
    if (p) begin
      bus0.b_req = 1; bus0.b_we = we; bus0.b_addr = addr; bus0.b_wdata = wd;
    end else begin
      bus0.a_req = 1; bus0.a_we = we; bus0.a_addr = addr; bus0.a_wdata = wd;
    end
    s.p = p;
    s.d = model[addr];
    sb_q.push_back(s);
    if (we) model[addr] = wd;
    @(negedge clk);
    g_p = p ? bus0.b_gnt : bus0.a_gnt;
    g_o = p ? bus0.a_gnt : bus0.b_gnt;
    tests++;
    if (g_p !== 1'b1 || g_o !== 1'b0) begin
      fails++;
      $display("FAIL gnt port=%0d got win=%b other=%b want 1/0", p, g_p, g_o);
    end
    tests++;
    if (bus0.mem_addr !== addr || bus0.mem_en !== we ||
        (we && bus0.mem_wdata !== wd)) begin
      fails++;
      $display("FAIL mem_bus got addr=%h en=%b wd=%h want addr=%h en=%b wd=%h",
               bus0.mem_addr, bus0.mem_en, bus0.mem_wdata, addr, we, wd);
    end
    bus0.a_req = 0;
    bus0.b_req = 0;
    @(negedge clk);
    d_p = p ? bus0.b_done : bus0.a_done;
    d_o = p ? bus0.a_done : bus0.b_done;
    tests++;
    if (d_p !== 1'b1 || d_o !== 1'b0 || bus0.mem_en !== 1'b0) begin
      fails++;
      $display("FAIL done port=%0d got win=%b other=%b en=%b want 1/0/0",
               p, d_p, d_o, bus0.mem_en);
    end
    s = sb_q.pop_front();
    rd_p = s.p ? bus0.b_rdata : bus0.a_rdata;
    rd_o = s.p ? bus0.a_rdata : bus0.b_rdata;
    tests++;
    if (rd_p !== s.d) begin
      fails++;
      $display("FAIL rdata port=%0d addr=%h got %h want %h", s.p, addr, rd_p, s.d);
    end
    tests++;
    if (rd_o !== last_rd[!s.p]) begin
      fails++;
      $display("FAIL rdata_hold got %h want %h", rd_o, last_rd[!s.p]);
    end
    last_rd[s.p] = s.d;
    @(negedge clk);
    tests++;
    if (en_cnt - en0 !== (we ? 1 : 0) || bus0.busy !== 1'b0) begin
      fails++;
      $display("FAIL en_count got %0d busy=%b want %0d busy=0",
               en_cnt - en0, bus0.busy, we ? 1 : 0);
    end
  endtask

  task automatic test_reset;
    do_reset;
    tests++;
    if ({bus0.a_gnt, bus0.a_done, bus0.b_gnt, bus0.b_done, bus0.mem_en,
         bus0.busy, bus0.a_rdata, bus0.b_rdata, bus0.mem_addr,
         bus0.mem_wdata, bus1.busy} !== '0) begin
      fails++;
      $display("FAIL reset_state got nonzero outputs want all 0");
    end
    do_op(1'b0, 1'b0, 5'h1B, 8'h00);
    tests++;
    if (last_rd[0] !== 8'hFF) begin
      fails++;
      $display("FAIL read_1b expected-model got %h want ff", last_rd[0]);
    end
  endtask

  task automatic test_write_read;
    do_op(1'b0, 1'b1, 5'h03, 8'h5C);
    do_op(1'b1, 1'b0, 5'h03, 8'h00);
    tests++;
    if (mem0[3] !== 8'h5C) begin
      fails++;
      $display("FAIL mem_write got %h want 5c", mem0[3]);
    end
  endtask

  task automatic test_range;
    do_op(1'b0, 1'b0, 5'h1F, 8'h00);
    do_op(1'b0, 1'b0, 5'h00, 8'h00);
    do_op(1'b1, 1'b1, 5'h1F, 8'h3C);
    do_op(1'b1, 1'b0, 5'h1F, 8'h00);
  endtask

  task automatic test_rr;
    bit exp_q [$];
    int cyc;
    int last;
    do_reset;
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    bus0.a_req = 1; bus0.a_we = 0; bus0.a_addr = 5'h10;
    bus0.b_req = 1; bus0.b_we = 0; bus0.b_addr = 5'h11;
    cyc = 0;
    last = -1;
    while (exp_q.size() > 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus0.a_gnt || bus0.b_gnt) begin
        bit e;
        e = exp_q.pop_front();
        tests++;
        if (bus0.b_gnt !== e || bus0.a_gnt !== !e) begin
          fails++;
          $display("FAIL rr_order got a=%b b=%b want b=%b", bus0.a_gnt, bus0.b_gnt, e);
        end
        if (last >= 0) begin
          tests++;
          if (cyc - last !== 3) begin
            fails++;
            $display("FAIL rr_spacing got %0d want 3", cyc - last);
          end
        end
        last = cyc;
      end
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL rr_timeout got %0d grants missing want 0", exp_q.size());
    end
    bus0.a_req = 0;
    bus0.b_req = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_fixed;
    bit exp_q [$];
    int cyc;
    int na;
    do_reset;
    exp_q = '{1'b0, 1'b0, 1'b0, 1'b1};
    bus1.a_req = 1; bus1.a_we = 0; bus1.a_addr = 5'h02;
    bus1.b_req = 1; bus1.b_we = 0; bus1.b_addr = 5'h05;
    cyc = 0;
    na = 0;
    while (exp_q.size() > 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus1.a_gnt || bus1.b_gnt) begin
        bit e;
        e = exp_q.pop_front();
        tests++;
        if (bus1.b_gnt !== e || bus1.a_gnt !== !e) begin
          fails++;
          $display("FAIL fixed_order got a=%b b=%b want b=%b", bus1.a_gnt, bus1.b_gnt, e);
        end
        if (bus1.a_gnt) begin
          na++;
          if (na == 3) bus1.a_req = 0;
        end else begin
          bus1.b_req = 0;
        end
      end
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL fixed_timeout got %0d grants missing want 0", exp_q.size());
    end
    bus1.a_req = 0;
    bus1.b_req = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_abort;
    do_reset;
    bus0.b_req = 1; bus0.b_we = 1; bus0.b_addr = 5'h1C; bus0.b_wdata = 8'h33;
    @(negedge clk);
    tests++;
    if (bus0.b_gnt !== 1'b1 || bus0.mem_en !== 1'b1) begin
      fails++;
      $display("FAIL abort_pre got gnt=%b en=%b want 1/1", bus0.b_gnt, bus0.mem_en);
    end
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if (bus0.mem_en !== 1'b0 || bus0.busy !== 1'b0 || bus0.b_gnt !== 1'b0) begin
      fails++;
      $display("FAIL abort_en got en=%b busy=%b gnt=%b want 0/0/0",
               bus0.mem_en, bus0.busy, bus0.b_gnt);
    end
    bus0.b_req = 0;
    @(negedge clk);
    tests++;
    if (bus0.b_done !== 1'b0 || mem0[28] !== 8'hAA) begin
      fails++;
      $display("FAIL abort_nowrite got done=%b mem=%h want 0/aa", bus0.b_done, mem0[28]);
    end
    rst_n = 1'b1;
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    @(negedge clk);
    tests++;
    if (bus0.b_done !== 1'b0 || bus0.busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_nodone got done=%b busy=%b want 0/0", bus0.b_done, bus0.busy);
    end
    do_op(1'b0, 1'b0, 5'h1C, 8'h00);
    tests++;
    if (last_rd[0] !== 8'hAA) begin
      fails++;
      $display("FAIL abort_read expected-model got %h want aa", last_rd[0]);
    end
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    en_cnt = 0;
    rst_n  = 1'b0;
    for (int i = 0; i < 32; i++) begin
      mem0[i]  = 8'hAA;
      mem1[i]  = 8'hAA;
      model[i] = 8'hAA;
    end
    mem0[27] = 8'hFF; model[27] = 8'hFF;
    mem0[3]  = 8'h00; model[3]  = 8'h00;
    mem0[31] = 8'h7E; model[31] = 8'h7E;
    mem0[0]  = 8'h81; model[0]  = 8'h81;
    clear_inputs;
    test_reset;
    test_write_read;
    test_range;
    test_rr;
    test_fixed;
    test_reset_abort;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
